// File: rtl/cd_sub.sv
// Single-cycle CPU datapath with a 16-entry register file, ALU, flags and a return-address stack.
// Optional carry/borrow flag is enabled by defining CD_SUB_CARRY_EN; otherwise c is tied to 0.
module cd_sub #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int PC_W        = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instr,
  output logic [PC_W-1:0] pc,
  input  logic            s_inc,
  input  logic            s_inm,
  input  logic            we3,
  input  logic            wez,
  input  logic [2:0]      op_alu,
  input  logic            s_call,
  input  logic            s_ret,
  output logic            z,
  output logic            c,
  output logic [5:0]      opcode,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [DATA_W-1:0] r_rf [16];
  logic [PC_W-1:0]   r_stack [STACK_DEPTH];
  logic [PC_W-1:0]   r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_z;
  logic              r_err;

  logic [3:0]        w_ra1, w_ra2, w_wa3;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_y, w_wd3;
  logic              w_zalu;
  logic [PC_W-1:0]   w_pc_inc, w_jmp, w_top;
  logic [SP_W-1:0]   w_sp_m1;
  logic [IDX_W-1:0]  w_push_idx, w_pop_idx;
  logic              w_full, w_empty;

  assign w_ra1 = instr[11:8];
  assign w_ra2 = instr[7:4];
  assign w_wa3 = instr[3:0];

  // r0 is hard-wired to zero on the read side; its storage is never written.
  assign w_rd1 = (w_ra1 == 4'd0) ? '0 : r_rf[w_ra1];
  assign w_rd2 = (w_ra2 == 4'd0) ? '0 : r_rf[w_ra2];

  always_comb begin
    w_y = '0;
    case (op_alu)
      3'b000:  w_y = w_rd1;
      3'b001:  w_y = ~w_rd1;
      3'b010:  w_y = w_rd1 + w_rd2;
      3'b011:  w_y = w_rd1 - w_rd2;
      3'b100:  w_y = w_rd1 & w_rd2;
      3'b101:  w_y = w_rd1 | w_rd2;
      3'b110:  w_y = DATA_W'(0) - w_rd1;
      default: w_y = DATA_W'(0) - w_rd2;
    endcase
  end

  assign w_zalu = (w_y == '0);
  assign w_wd3  = s_inm ? DATA_W'(instr[11:4]) : w_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else if (we3 && (w_wa3 != 4'd0)) begin
      r_rf[w_wa3] <= w_wd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   r_z <= 1'b0;
    else if (wez) r_z <= w_zalu;
  end

`ifdef CD_SUB_CARRY_EN
  logic [DATA_W:0] w_sum;
  logic            w_calu;
  logic            r_c;

  assign w_sum = {1'b0, w_rd1} + {1'b0, w_rd2};

  always_comb begin
    w_calu = 1'b0;
    case (op_alu)
      3'b010:  w_calu = w_sum[DATA_W];
      3'b011:  w_calu = (w_rd1 < w_rd2);
      default: w_calu = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   r_c <= 1'b0;
    else if (wez) r_c <= w_calu;
  end

  assign c = r_c;
`else
  assign c = 1'b0;
`endif

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_jmp      = instr[PC_W-1:0];
  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_sp_m1    = r_sp - SP_W'(1);
  assign w_push_idx = r_sp[IDX_W-1:0];
  assign w_pop_idx  = w_sp_m1[IDX_W-1:0];
  assign w_top      = r_stack[w_pop_idx];

  // Return beats call; a call on a full stack still jumps but loses its return address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= '0;
      r_sp  <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (s_ret) begin
      if (!w_empty) begin
        r_pc <= w_top;
        r_sp <= w_sp_m1;
      end else begin
        r_pc  <= w_pc_inc;
        r_err <= 1'b1;
      end
    end else if (s_call) begin
      r_pc <= w_jmp;
      if (!w_full) begin
        r_stack[w_push_idx] <= w_pc_inc;
        r_sp                <= r_sp + SP_W'(1);
      end else begin
        r_err <= 1'b1;
      end
    end else begin
      r_pc <= s_inc ? w_pc_inc : w_jmp;
    end
  end

  assign pc          = r_pc;
  assign z           = r_z;
  assign opcode      = instr[15:10];
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_err   = r_err;

endmodule

// File: tb/tb_cd_sub.sv
// Directed, table-driven bench for cd_sub (default parameters: DATA_W=8, STACK_DEPTH=4).
module tb_cd_sub;

`ifdef CD_SUB_CARRY_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [9:0]  pc;
  logic        s_inc, s_inm, we3, wez, s_call, s_ret;
  logic [2:0]  op_alu;
  logic        z, c;
  logic [5:0]  opcode;
  logic        stack_full, stack_empty, stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cd_sub dut (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op_alu(op_alu),
    .s_call(s_call), .s_ret(s_ret), .z(z), .c(c), .opcode(opcode),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  typedef struct {
    logic [15:0] ins;
    logic        inc, inm, w3, wz;
    logic [2:0]  op;
    logic        cl, rt;
    logic [9:0]  e_pc;
    logic        e_z, e_c, e_full, e_empty, e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [15:0] ins, logic inc, logic inm, logic w3, logic wz,
                              logic [2:0] op, logic cl, logic rt, logic [9:0] e_pc,
                              logic e_z, logic e_c, logic e_full, logic e_empty, logic e_err);
    vec_t v;
    v.ins = ins; v.inc = inc; v.inm = inm; v.w3 = w3; v.wz = wz; v.op = op;
    v.cl = cl; v.rt = rt; v.e_pc = e_pc; v.e_z = e_z; v.e_c = e_c;
    v.e_full = e_full; v.e_empty = e_empty; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    instr = 16'h0000; s_inc = 1'b1; s_inm = 1'b0; we3 = 1'b0; wez = 1'b0;
    op_alu = 3'b000; s_call = 1'b0; s_ret = 1'b0;
  endtask

  task automatic step(input vec_t v, input string tag);
    instr = v.ins; s_inc = v.inc; s_inm = v.inm; we3 = v.w3; wez = v.wz;
    op_alu = v.op; s_call = v.cl; s_ret = v.rt;
    @(posedge clk);
    #1;
    chk({tag, ".pc"},    32'(pc),          32'(v.e_pc));
    chk({tag, ".z"},     32'(z),           32'(v.e_z));
    chk({tag, ".c"},     32'(c),           32'(v.e_c & CE));
    chk({tag, ".full"},  32'(stack_full),  32'(v.e_full));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(v.e_empty));
    chk({tag, ".err"},   32'(stack_err),   32'(v.e_err));
  endtask

  initial begin
    //          instr    inc inm w3 wz op  cl rt  pc      z  c  fl em er
    tv.push_back(mk(16'h05A3, 1, 1, 1, 0, 3'd0, 0, 0, 10'h001, 0, 0, 0, 1, 0)); // r3=5A
    tv.push_back(mk(16'h0254, 1, 1, 1, 0, 3'd0, 0, 0, 10'h002, 0, 0, 0, 1, 0)); // r4=25
    tv.push_back(mk(16'h0345, 1, 0, 1, 1, 3'd2, 0, 0, 10'h003, 0, 0, 0, 1, 0)); // r5=7F
    tv.push_back(mk(16'h0556, 1, 0, 1, 1, 3'd3, 0, 0, 10'h004, 1, 0, 0, 1, 0)); // r6=0
    tv.push_back(mk(16'h0FF7, 1, 1, 1, 0, 3'd0, 0, 0, 10'h005, 1, 0, 0, 1, 0)); // r7=FF
    tv.push_back(mk(16'h0018, 1, 1, 1, 0, 3'd0, 0, 0, 10'h006, 1, 0, 0, 1, 0)); // r8=01
    tv.push_back(mk(16'h0789, 1, 0, 1, 1, 3'd2, 0, 0, 10'h007, 1, 1, 0, 1, 0)); // FF+01
    tv.push_back(mk(16'h003A, 1, 1, 1, 0, 3'd0, 0, 0, 10'h008, 1, 1, 0, 1, 0)); // r10=03
    tv.push_back(mk(16'h005B, 1, 1, 1, 0, 3'd0, 0, 0, 10'h009, 1, 1, 0, 1, 0)); // r11=05
    tv.push_back(mk(16'h0ABC, 1, 0, 1, 1, 3'd3, 0, 0, 10'h00A, 0, 1, 0, 1, 0)); // 03-05
    tv.push_back(mk(16'h0780, 1, 0, 1, 1, 3'd4, 0, 0, 10'h00B, 0, 0, 0, 1, 0)); // and, wr r0
    tv.push_back(mk(16'h0000, 1, 0, 0, 1, 3'd0, 0, 0, 10'h00C, 1, 0, 0, 1, 0)); // r0 reads 0
    tv.push_back(mk(16'h0700, 1, 0, 0, 1, 3'd1, 0, 0, 10'h00D, 1, 0, 0, 1, 0)); // ~FF
    tv.push_back(mk(16'h0080, 1, 0, 0, 1, 3'd7, 0, 0, 10'h00E, 0, 0, 0, 1, 0)); // -b
    tv.push_back(mk(16'h0700, 1, 0, 0, 1, 3'd6, 0, 0, 10'h00F, 0, 0, 0, 1, 0)); // -a
    tv.push_back(mk(16'h0000, 1, 0, 0, 1, 3'd5, 0, 0, 10'h010, 1, 0, 0, 1, 0)); // 0|0
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 0, 10'h155, 1, 0, 0, 1, 0)); // jump
    tv.push_back(mk(16'h03FF, 0, 0, 0, 0, 3'd0, 0, 0, 10'h3FF, 1, 0, 0, 1, 0));
    tv.push_back(mk(16'h0000, 1, 0, 0, 0, 3'd0, 0, 0, 10'h000, 1, 0, 0, 1, 0)); // wrap
    tv.push_back(mk(16'h0010, 0, 0, 0, 0, 3'd0, 0, 0, 10'h010, 1, 0, 0, 1, 0));
    tv.push_back(mk(16'h0200, 1, 0, 0, 0, 3'd0, 1, 0, 10'h200, 1, 0, 0, 0, 0)); // call
    tv.push_back(mk(16'h0300, 1, 0, 0, 0, 3'd0, 1, 0, 10'h300, 1, 0, 0, 0, 0));
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h201, 1, 0, 0, 0, 0)); // ret
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h011, 1, 0, 0, 1, 0));
    tv.push_back(mk(16'h0100, 1, 0, 0, 0, 3'd0, 1, 0, 10'h100, 1, 0, 0, 0, 0)); // 5 calls
    tv.push_back(mk(16'h0101, 1, 0, 0, 0, 3'd0, 1, 0, 10'h101, 1, 0, 0, 0, 0));
    tv.push_back(mk(16'h0102, 1, 0, 0, 0, 3'd0, 1, 0, 10'h102, 1, 0, 0, 0, 0));
    tv.push_back(mk(16'h0103, 1, 0, 0, 0, 3'd0, 1, 0, 10'h103, 1, 0, 1, 0, 0));
    tv.push_back(mk(16'h0104, 1, 0, 0, 0, 3'd0, 1, 0, 10'h104, 1, 0, 1, 0, 1)); // overflow
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h103, 1, 0, 0, 0, 1)); // 5 rets
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h102, 1, 0, 0, 0, 1));
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h101, 1, 0, 0, 0, 1));
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h012, 1, 0, 0, 1, 1));
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h013, 1, 0, 0, 1, 1)); // underflow
    tv.push_back(mk(16'h02AA, 1, 0, 0, 0, 3'd0, 1, 0, 10'h2AA, 1, 0, 0, 0, 1));
    tv.push_back(mk(16'h0155, 1, 0, 0, 0, 3'd0, 1, 1, 10'h014, 1, 0, 0, 1, 1)); // call+ret
    tv.push_back(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h015, 1, 0, 0, 1, 1));

    reset = 1'b0;
    idle();
    instr = 16'hA800;
    #1;
    chk("opcode", 32'(opcode), 32'h2A);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc",    32'(pc),          32'h0);
    chk("rst.z",     32'(z),           32'h0);
    chk("rst.c",     32'(c),           32'h0);
    chk("rst.full",  32'(stack_full),  32'h0);
    chk("rst.empty", 32'(stack_empty), 32'h1);
    chk("rst.err",   32'(stack_err),   32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) step(tv[i], $sformatf("v%0d", i));

    chk("rf.r3", 32'(dut.r_rf[3]), 32'h5A);
    chk("rf.r4", 32'(dut.r_rf[4]), 32'h25);
    chk("rf.r5", 32'(dut.r_rf[5]), 32'h7F);
    chk("rf.r6", 32'(dut.r_rf[6]), 32'h00);

    // Reset in the middle of a cycle with a live stack entry and a sticky error.
    step(mk(16'h02AA, 1, 0, 0, 0, 3'd0, 1, 0, 10'h2AA, 1, 0, 0, 0, 1), "pre");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst.pc",    32'(pc),           32'h0);
    chk("arst.empty", 32'(stack_empty),  32'h1);
    chk("arst.err",   32'(stack_err),    32'h0);
    chk("arst.z",     32'(z),            32'h0);
    chk("arst.r5",    32'(dut.r_rf[5]),  32'h0);
    idle();
    @(negedge clk);
    reset = 1'b1;

    // Return address of a call at 1023 wraps to 0, then a fresh underflow sets the error.
    step(mk(16'h03FF, 0, 0, 0, 0, 3'd0, 0, 0, 10'h3FF, 0, 0, 0, 1, 0), "w0");
    step(mk(16'h0050, 1, 0, 0, 0, 3'd0, 1, 0, 10'h050, 0, 0, 0, 0, 0), "w1");
    step(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h000, 0, 0, 0, 1, 0), "w2");
    step(mk(16'h0155, 0, 0, 0, 0, 3'd0, 0, 1, 10'h001, 0, 0, 0, 1, 1), "w3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
